seq_div16x8: RTL

Sequential restoring divider, the inverse operator to the team's 8x8 Wallace-tree multiplier: a 16-bit product-width dividend is divided by an 8-bit divisor, giving a 16-bit quotient and an 8-bit remainder. It sits beside the multiplier in the arithmetic datapath, with valid/ready handshakes on input and output. It computes one quotient bit per cycle to keep area small.

---
 rtl/seq_div16x8_pkg.sv | 24 ++
 rtl/seq_div16x8_div_step.sv | 22 ++
 rtl/seq_div16x8.sv | 104 ++++++++++
 3 files changed

// File: rtl/seq_div16x8_pkg.sv
// Shared arithmetic constants and FSM encoding for the 16/8 sequential divider.
// APPROX_LSBS only takes effect when APPROX_DIV_EN is defined.
package seq_div16x8_pkg;

  localparam int DIVIDEND_W  = 16;
  localparam int DIVISOR_W   = 8;
  localparam int APPROX_LSBS = 4;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_CALC = 2'd1;
  localparam state_t S_DONE = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  localparam int CNT_W = clog2(DIVIDEND_W + 1);

endpackage

// File: rtl/seq_div16x8_div_step.sv
// One combinational restoring-division step.
// Macro APPROX_DIV_EN (handled in the top) does not affect this module.
module seq_div16x8_div_step
  import seq_div16x8_pkg::*;
(
  input  logic [DIVISOR_W-1:0] i_pr,
  input  logic                 i_bit,
  input  logic [DIVISOR_W-1:0] i_divisor,
  output logic [DIVISOR_W-1:0] o_pr,
  output logic                 o_qbit
);

  logic [DIVISOR_W:0]   w_sh;
  logic [DIVISOR_W-1:0] w_diff;

  // The shifted value needs one extra bit; after restoring it fits again.
  assign w_sh   = {i_pr, i_bit};
  assign o_qbit = (w_sh >= {1'b0, i_divisor});
  assign w_diff = w_sh[DIVISOR_W-1:0] - i_divisor;
  assign o_pr   = o_qbit ? w_diff : w_sh[DIVISOR_W-1:0];

endmodule

// File: rtl/seq_div16x8.sv
// Sequential restoring divider, one quotient bit per cycle.
// Macro APPROX_DIV_EN skips the low APPROX_LSBS dividend bits.
module seq_div16x8
  import seq_div16x8_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

`ifdef APPROX_DIV_EN
  localparam int SKIP = APPROX_LSBS;
`else
  localparam int SKIP = 0;
`endif
  localparam int N_IT = DIVIDEND_W - SKIP;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_IT - 1);

  state_t                r_state;
  logic [CNT_W-1:0]      r_cnt;
  logic [DIVIDEND_W-1:0] r_dvd;
  logic [DIVIDEND_W-1:0] r_quo;
  logic [DIVISOR_W-1:0]  r_pr;
  logic [DIVISOR_W-1:0]  r_dsr;
  logic                  r_dz;

  logic [DIVISOR_W-1:0]  w_pr;
  logic                  w_qbit;
  logic [DIVIDEND_W-1:0] w_quo;

  seq_div16x8_div_step u_step (
    .i_pr      (r_pr),
    .i_bit     (r_dvd[DIVIDEND_W-1]),
    .i_divisor (r_dsr),
    .o_pr      (w_pr),
    .o_qbit    (w_qbit)
  );

  assign w_quo = {r_quo[DIVIDEND_W-2:0], w_qbit};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dvd   <= '0;
      r_quo   <= '0;
      r_pr    <= '0;
      r_dsr   <= '0;
      r_dz    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_dsr <= divisor;
            r_cnt <= '0;
            if (divisor == '0) begin
              r_quo   <= '1;
              r_pr    <= dividend[DIVISOR_W-1:0];
              r_dz    <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_dvd   <= dividend;
              r_quo   <= '0;
              r_pr    <= '0;
              r_dz    <= 1'b0;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          r_dvd <= {r_dvd[DIVIDEND_W-2:0], 1'b0};
          r_pr  <= w_pr;
          r_cnt <= r_cnt + 1'b1;
          // Approx mode re-aligns the short quotient to full weight.
          if (r_cnt == LAST) begin
            r_quo   <= w_quo << SKIP;
            r_state <= S_DONE;
          end else begin
            r_quo <= w_quo;
          end
        end
        S_DONE: begin
          if (out_ready) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready    = (r_state == S_IDLE);
  assign out_valid   = (r_state == S_DONE);
  assign quotient    = r_quo;
  assign remainder   = r_pr;
  assign div_by_zero = r_dz;

endmodule
